// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared SPARC opcode constants, stage states and memory-op decode
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    localparam logic [1:0] OP_FMT2 = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_MEM  = 2'b11;

    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_LD   = 6'b000000;
    localparam logic [5:0] OP3_LDUB = 6'b000001;
    localparam logic [5:0] OP3_LDUH = 6'b000010;
    localparam logic [5:0] OP3_LDSB = 6'b001001;
    localparam logic [5:0] OP3_LDSH = 6'b001010;
    localparam logic [5:0] OP3_ST   = 6'b000100;
    localparam logic [5:0] OP3_STB  = 6'b000101;
    localparam logic [5:0] OP3_STH  = 6'b000110;

    typedef struct packed {
        logic      is_mem;
        logic      we;
        logic      sign_ext;
        mem_size_t size;
    } mem_decode_t;

    function automatic mem_decode_t decode_mem(input logic [5:0] op3);
        mem_decode_t d;
        d = '0;
        d.size = SIZE_WORD;
        case (op3)
            OP3_LD:   d.is_mem = 1'b1;
            OP3_LDUB: begin d.is_mem = 1'b1; d.size = SIZE_BYTE; end
            OP3_LDUH: begin d.is_mem = 1'b1; d.size = SIZE_HALF; end
            OP3_LDSB: begin d.is_mem = 1'b1; d.size = SIZE_BYTE; d.sign_ext = 1'b1; end
            OP3_LDSH: begin d.is_mem = 1'b1; d.size = SIZE_HALF; d.sign_ext = 1'b1; end
            OP3_ST:   begin d.is_mem = 1'b1; d.we = 1'b1; end
            OP3_STB:  begin d.is_mem = 1'b1; d.we = 1'b1; d.size = SIZE_BYTE; end
            OP3_STH:  begin d.is_mem = 1'b1; d.we = 1'b1; d.size = SIZE_HALF; end
            default:  d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_aligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return (offset[0] == 1'b0);
            default:   return (offset == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - big-endian lane select with zero/sign extension for load data
module load_align
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  mem_size_t             size,
    input  logic                  sign_ext,
    output logic [DATA_WIDTH-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Offset 0 is the most significant lane of the returned word.
    always_comb begin
        byte_lane = 8'(rdata >> (DATA_WIDTH - 8 - 8 * offset));
        half_lane = 16'(rdata >> (DATA_WIDTH - 16 - 8 * offset));
        case (size)
            SIZE_BYTE: result = {{(DATA_WIDTH-8){sign_ext & byte_lane[7]}}, byte_lane};
            SIZE_HALF: result = {{(DATA_WIDTH-16){sign_ext & half_lane[15]}}, half_lane};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - SPARC memory-access stage: data-bus request FSM and register writeback
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MEM_valid_in,
    input  logic [DATA_WIDTH-1:0] MEM_alures_in,
    input  logic [DATA_WIDTH-1:0] MEM_storedata_in,
    input  logic [4:0]            MEM_regD_in,
    input  logic [1:0]            MEM_op_in,
    input  logic [2:0]            MEM_op2_in,
    input  logic [5:0]            MEM_op3_in,
    output logic                  mem_ready,
    output logic                  dbus_req_valid,
    output logic [ADDR_WIDTH-1:0] dbus_req_addr,
    output logic                  dbus_req_we,
    output logic [1:0]            dbus_req_size,
    output logic [DATA_WIDTH-1:0] dbus_req_wdata,
    input  logic                  dbus_req_ready,
    input  logic                  dbus_resp_valid,
    input  logic [DATA_WIDTH-1:0] dbus_resp_data,
    output logic                  MEM_wb_valid,
    output logic [4:0]            MEM_wb_regD,
    output logic [DATA_WIDTH-1:0] MEM_wb_data,
    output logic                  MEM_misalign_out
);

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    mem_size_t             size_q, size_d;
    logic                  we_q, we_d;
    logic                  sign_q, sign_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]            regd_q, regd_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [4:0]            wb_regd_q, wb_regd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  misalign_q, misalign_d;

    mem_decode_t           dec;
    logic                  wb_op;
    logic [DATA_WIDTH-1:0] load_data;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rdata    (dbus_resp_data),
        .offset   (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (sign_q),
        .result   (load_data)
    );

    always_comb begin
        dec   = decode_mem(MEM_op3_in);
        wb_op = (MEM_op_in == OP_ALU) || (MEM_op_in == OP_CALL) ||
                (MEM_op_in == OP_FMT2 && MEM_op2_in == OP2_SETHI);

        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        we_d       = we_q;
        sign_d     = sign_q;
        wdata_d    = wdata_q;
        regd_d     = regd_q;
        wb_valid_d = 1'b0;
        wb_regd_d  = wb_regd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MEM_valid_in) begin
                    if (MEM_op_in == OP_MEM) begin
                        if (dec.is_mem && is_aligned(dec.size, MEM_alures_in[1:0])) begin
                            state_d = ST_REQ;
                            addr_d  = ADDR_WIDTH'(MEM_alures_in);
                            size_d  = dec.size;
                            we_d    = dec.we;
                            sign_d  = dec.sign_ext;
                            regd_d  = MEM_regD_in;
                            // Narrow stores drive every lane so the bus can pick by byte enable.
                            case (dec.size)
                                SIZE_BYTE: wdata_d = {(DATA_WIDTH/8){MEM_storedata_in[7:0]}};
                                SIZE_HALF: wdata_d = {(DATA_WIDTH/16){MEM_storedata_in[15:0]}};
                                default:   wdata_d = MEM_storedata_in;
                            endcase
                            if (!dec.we) begin
                                wdata_d = '0;
                            end
                        end else if (dec.is_mem) begin
                            misalign_d = 1'b1;
                        end
                    end else if (wb_op) begin
                        wb_valid_d = (MEM_regD_in != 5'd0);
                        wb_regd_d  = MEM_regD_in;
                        wb_data_d  = MEM_alures_in;
                    end
                end
            end
            ST_REQ: begin
                if (dbus_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dbus_resp_valid) begin
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        wb_valid_d = (regd_q != 5'd0);
                        wb_regd_d  = regd_q;
                        wb_data_d  = load_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= SIZE_BYTE;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            wdata_q    <= '0;
            regd_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_regd_q  <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            we_q       <= we_d;
            sign_q     <= sign_d;
            wdata_q    <= wdata_d;
            regd_q     <= regd_d;
            wb_valid_q <= wb_valid_d;
            wb_regd_q  <= wb_regd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem_ready        = (state_q == ST_IDLE);
    assign dbus_req_valid   = (state_q == ST_REQ);
    assign dbus_req_addr    = addr_q;
    assign dbus_req_we      = we_q;
    assign dbus_req_size    = size_q;
    assign dbus_req_wdata   = wdata_q;
    assign MEM_wb_valid     = wb_valid_q;
    assign MEM_wb_regD      = wb_regd_q;
    assign MEM_wb_data      = wb_data_q;
    assign MEM_misalign_out = misalign_q;

endmodule
